// File: rtl/event_pkg.sv
// Shared definitions for the event-record path: codes, field offsets and the
// stamping helper used by event_stamper.
package event_pkg;

  localparam int unsigned RECORD_WIDTH = 256;

  localparam logic [7:0] CODE_UNDERFLOW   = 8'd1;
  localparam logic [7:0] CODE_JOBCOMPLETE = 8'd2;
  localparam logic [7:0] CODE_EVENT_B     = 8'd3;

  localparam int unsigned CODE_LSB  = 0;
  localparam int unsigned SEQ_LSB   = 32;
  localparam int unsigned TS_LSB    = 64;
  localparam int unsigned MAGIC_LSB = 248;

  localparam logic [7:0] MAGIC = 8'h01;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_MAIN  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Code and magic bytes plus [247:128] pass through; [31:8] is cleared.
  function automatic logic [RECORD_WIDTH-1:0] stamp_record(
    input logic [RECORD_WIDTH-1:0] rec,
    input logic [31:0]             seq,
    input logic [63:0]             ts
  );
    logic [RECORD_WIDTH-1:0] r;
    r                = rec;
    r[31:8]          = 24'd0;
    r[SEQ_LSB +: 32] = seq;
    r[TS_LSB +: 64]  = ts;
    return r;
  endfunction

endpackage

// File: rtl/event_stamper_if.sv
// AXI-stream style record channel used on both sides of event_stamper.
interface event_stamper_if #(
  parameter int DATA_WIDTH = 256
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: output always presents main; ready is the registered
// "skid empty" so the upstream path never sees a combinational dependency.
module axis_skid_buffer
  import event_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = in_valid & ready_q;
  assign out_fire = valid_q & out_ready;

  // Occupancy FSM; a take from main always promotes skid on the same edge.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = SKID_MAIN;
        end else begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_MAIN: begin
        case ({in_fire, out_fire})
          2'b10: begin
            skid_d  = in_data;
            state_d = SKID_FULL;
          end
          2'b01: state_d = SKID_EMPTY;
          2'b11: begin
            main_d  = in_data;
            state_d = SKID_MAIN;
          end
          default: state_d = SKID_MAIN;
        endcase
      end
      SKID_FULL: begin
        if (out_fire) begin
          main_d = skid_q;
          if (in_fire) begin
            skid_d  = in_data;
            state_d = SKID_FULL;
          end else begin
            state_d = SKID_MAIN;
          end
        end else begin
          state_d = SKID_FULL;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    valid_d = (state_d != SKID_EMPTY);
    ready_d = (state_d != SKID_FULL);
  end

  // State and handshake registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SKID_EMPTY;
      main_q  <= {DATA_WIDTH{1'b0}};
      skid_q  <= {DATA_WIDTH{1'b0}};
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/event_stamper.sv
// Stamps accepted event records with sequence number and cycle timestamp;
// records accepted while disabled are discarded and counted.
module event_stamper
  import event_pkg::*;
#(
  parameter int TS_WIDTH  = 64,
  parameter int SEQ_WIDTH = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  event_stamper_if.slave  axis_in,
  event_stamper_if.master axis_out,
  output logic [31:0]     drop_count
);

  logic [TS_WIDTH-1:0]     ts_q, ts_d;
  logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
  logic [31:0]             drop_q, drop_d;
  logic                    in_ready;
  logic                    accept;
  logic                    push;
  logic [RECORD_WIDTH-1:0] stamped;
  logic [RECORD_WIDTH-1:0] out_data;
  logic                    out_valid;

  assign accept  = axis_in.tvalid & in_ready;
  assign push    = accept & enable;
  assign stamped = stamp_record(axis_in.tdata, 32'(seq_q), 64'(ts_q));

  // Free-running timestamp, forwarded-record sequence and saturating drop count.
  always_comb begin
    ts_d   = ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
    seq_d  = seq_q;
    drop_d = drop_q;
    if (push) begin
      seq_d = seq_q + {{(SEQ_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      seq_d = seq_q;
    end
    if (accept && !enable && (drop_q != 32'hFFFF_FFFF)) begin
      drop_d = drop_q + 32'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts_q   <= {TS_WIDTH{1'b0}};
      seq_q  <= {SEQ_WIDTH{1'b0}};
      drop_q <= 32'd0;
    end else begin
      ts_q   <= ts_d;
      seq_q  <= seq_d;
      drop_q <= drop_d;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(RECORD_WIDTH)
  ) u_skid (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (stamped),
    .in_valid (push),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(axis_out.tready)
  );

  assign axis_in.tready  = in_ready;
  assign axis_out.tdata  = out_data;
  assign axis_out.tvalid = out_valid;
  assign drop_count      = drop_q;

endmodule

// File: tb/tb_event_stamper.sv
// Directed bench for event_stamper: table of records plus hand-written
// stall, wrap, saturation, random-handshake and mid-stream reset sequences.
module tb_event_stamper;
  import event_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] drop_count;

  event_stamper_if #(.DATA_WIDTH(256)) in_if ();
  event_stamper_if #(.DATA_WIDTH(256)) out_if ();

  event_stamper dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .axis_in   (in_if),
    .axis_out  (out_if),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en;
    logic [7:0]  code;
    logic [119:0] mid;
    logic [31:0] exp_seq;
    logic [31:0] exp_drop;
  } vec_t;

  vec_t         vecs [8];
  int           n_tests = 0;
  int           n_fail = 0;
  logic [63:0]  cyc;
  logic [255:0] exp_q [$];
  logic [255:0] got_q [$];
  logic [255:0] prev_data;
  bit           prev_stall = 1'b0;
  bit           done;
  logic [31:0]  model_seq;
  logic [255:0] r;

  // Reference cycle count: equals the timestamp a record accepted now must carry.
  always @(posedge clk) begin
    if (!resetn) cyc <= 64'd0;
    else         cyc <= cyc + 64'd1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Output monitor: collects transfers and checks stability while stalled.
  always @(negedge clk) begin
    #1;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 256'(out_if.tvalid), 256'd1);
        chk("stall_data", out_if.tdata, prev_data);
      end
      if (out_if.tvalid && out_if.tready) got_q.push_back(out_if.tdata);
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_data  = out_if.tdata;
    end
  end

  task automatic send(input bit en, input logic [7:0] code, input logic [119:0] mid,
                      input logic [31:0] seq);
    int waited = 0;
    in_if.tdata  = {MAGIC, mid, 64'hFFFF_0000_AAAA_5555, 32'hC3C3_C3C3, 24'hA5A5A5, code};
    in_if.tvalid = 1'b1;
    enable       = en;
    while (!in_if.tready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_if.tready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got tready=0 after %0d cycles, expected 1", waited);
      in_if.tvalid = 1'b0;
      return;
    end
    if (en) exp_q.push_back({MAGIC, mid, cyc, seq, 24'd0, code});
    @(negedge clk);
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (got_q.size() < exp_q.size() && w < 3000) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    chk({name, "_count"}, 256'(got_q.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk(name, got_q[i], exp_q[i]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn       = 1'b0;
    in_if.tvalid = 1'b0;
    enable       = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    resetn = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b0, CODE_UNDERFLOW,   120'h11, 32'd0, 32'd1};
    vecs[1] = '{1'b0, CODE_JOBCOMPLETE, 120'h22, 32'd0, 32'd2};
    vecs[2] = '{1'b0, CODE_EVENT_B,     120'h33, 32'd0, 32'd3};
    vecs[3] = '{1'b0, CODE_UNDERFLOW,   120'h44, 32'd0, 32'd4};
    vecs[4] = '{1'b1, CODE_JOBCOMPLETE, 120'h55, 32'd0, 32'd4};
    vecs[5] = '{1'b1, CODE_UNDERFLOW,   120'h66, 32'd1, 32'd4};
    vecs[6] = '{1'b0, CODE_EVENT_B,     120'h77, 32'd0, 32'd5};
    vecs[7] = '{1'b1, CODE_EVENT_B,     {8'hBE, 112'hEF}, 32'd2, 32'd5};

    in_if.tvalid  = 1'b0;
    in_if.tdata   = 256'd0;
    out_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 256'(in_if.tready), 256'd0);
    chk("rst_out_valid", 256'(out_if.tvalid), 256'd0);
    chk("rst_drop", 256'(drop_count), 256'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 256'(in_if.tready), 256'd1);

    // Test 1: single record at cycle 10, one-cycle latency.
    out_if.tready = 1'b1;
    while (cyc != 64'd10) @(negedge clk);
    send(1'b1, CODE_JOBCOMPLETE, 120'h1234, 32'd0);
    chk("t1_latency_valid", 256'(out_if.tvalid), 256'd1);
    #2;
    chk("t1_count", 256'(got_q.size()), 256'd1);
    r = (got_q.size() > 0) ? got_q[0] : 256'd0;
    chk("t1_code", 256'(r[7:0]), 256'h02);
    chk("t1_zero", 256'(r[31:8]), 256'd0);
    chk("t1_seq", 256'(r[63:32]), 256'd0);
    chk("t1_ts", 256'(r[127:64]), 256'd10);
    chk("t1_magic", 256'(r[255:248]), 256'h01);
    drain("t1");

    // Test 2: stall with back-to-back records; buffer fills after two.
    do_reset();
    out_if.tready = 1'b0;
    fork
      begin
        send(1'b1, CODE_UNDERFLOW, 120'hA1, 32'd0);
        send(1'b1, CODE_JOBCOMPLETE, 120'hA2, 32'd1);
        chk("t2_ready_low", 256'(in_if.tready), 256'd0);
        send(1'b1, CODE_EVENT_B, 120'hA3, 32'd2);
      end
      begin
        repeat (5) @(negedge clk);
        out_if.tready = 1'b1;
      end
    join
    drain("t2");

    // Test 3: table of enabled/disabled records.
    do_reset();
    out_if.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].en, vecs[i].code, vecs[i].mid, vecs[i].exp_seq);
      chk("t3_drop", 256'(drop_count), 256'(vecs[i].exp_drop));
    end
    drain("t3");

    // Test 4: sequence wrap and drop-count saturation.
    do_reset();
    @(negedge clk);
    force dut.seq_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.seq_q;
    send(1'b1, CODE_UNDERFLOW, 120'hB1, 32'hFFFF_FFFE);
    send(1'b1, CODE_JOBCOMPLETE, 120'hB2, 32'hFFFF_FFFF);
    send(1'b1, CODE_EVENT_B, 120'hB3, 32'h0000_0000);
    force dut.drop_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.drop_q;
    send(1'b0, CODE_UNDERFLOW, 120'hB4, 32'd0);
    chk("t4_drop_top", 256'(drop_count), 256'hFFFF_FFFF);
    send(1'b0, CODE_UNDERFLOW, 120'hB5, 32'd0);
    chk("t4_drop_sat", 256'(drop_count), 256'hFFFF_FFFF);
    drain("t4");

    // Test 5: random valid gaps and random downstream ready.
    do_reset();
    model_seq = 32'd0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(1'b1, 8'(i % 3 + 1), 120'(i * 7 + 3), model_seq);
          model_seq = model_seq + 32'd1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_if.tready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
    join
    out_if.tready = 1'b1;
    drain("t5");

    // Test 6: reset with main and skid both occupied.
    do_reset();
    out_if.tready = 1'b0;
    send(1'b0, CODE_EVENT_B, 120'hC0, 32'd0);
    send(1'b1, CODE_UNDERFLOW, 120'hC1, 32'd0);
    send(1'b1, CODE_JOBCOMPLETE, 120'hC2, 32'd1);
    chk("t6_pre_drop", 256'(drop_count), 256'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("t6_valid_low", 256'(out_if.tvalid), 256'd0);
    chk("t6_drop_clr", 256'(drop_count), 256'd0);
    chk("t6_ready_low", 256'(in_if.tready), 256'd0);
    exp_q.delete();
    got_q.delete();
    resetn = 1'b1;
    out_if.tready = 1'b1;
    send(1'b1, CODE_EVENT_B, 120'hC3, 32'd0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
